hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 43 ++++
 rtl/hazard_fwd_sel.sv | 45 ++++
 rtl/hazard_ctrl.sv | 105 ++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: result kinds,
// forwarding-select codes, the "operand unused" tuse value and the stage record.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_ALU  = 2'd1,
        KIND_LINK = 2'd2,
        KIND_MEM  = 2'd3
    } kind_e;

    localparam logic [3:0] SEL_RF     = 4'd0;
    localparam logic [3:0] SEL_ALUC_M = 4'd1;
    localparam logic [3:0] SEL_PC4_M  = 4'd2;
    localparam logic [3:0] SEL_ALUC_W = 4'd3;
    localparam logic [3:0] SEL_DMRD_W = 4'd4;

    localparam logic [1:0] TUSE_UNUSED = 2'd3;

    typedef struct packed {
        logic [4:0] a3;
        kind_e      kind;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
    } stage_rec_t;

    // Cycles from entering E until the result exists in the pipeline.
    function automatic logic [1:0] tnew_init(input kind_e kind);
        logic [1:0] t;
        case (kind)
            KIND_ALU, KIND_LINK: t = 2'd1;
            KIND_MEM:            t = 2'd2;
            default:             t = 2'd0;
        endcase
        return t;
    endfunction

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding-select for one source register: the younger M record wins over W;
// an M producer whose value is not yet ready blocks the stale W value.
module hazard_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0]  src_i,
    input  stage_rec_t  m_rec_i,
    input  stage_rec_t  w_rec_i,
    output logic [3:0]  sel_o
);

    logic [3:0] sel_s;
    logic       unused_fields_s;

    assign unused_fields_s = ^{m_rec_i.rs, m_rec_i.rt, w_rec_i.tnew, w_rec_i.rs, w_rec_i.rt};

    // Priority select: register 0 and a3==0 never match.
    always_comb begin
        sel_s = SEL_RF;
        if (src_i == 5'd0) begin
            sel_s = SEL_RF;
        end else if (m_rec_i.a3 == src_i) begin
            if (m_rec_i.tnew == 2'd0) begin
                case (m_rec_i.kind)
                    KIND_ALU:  sel_s = SEL_ALUC_M;
                    KIND_LINK: sel_s = SEL_PC4_M;
                    default:   sel_s = SEL_RF;
                endcase
            end else begin
                sel_s = SEL_RF;
            end
        end else if (w_rec_i.a3 == src_i) begin
            case (w_rec_i.kind)
                KIND_ALU, KIND_LINK: sel_s = SEL_ALUC_W;
                KIND_MEM:            sel_s = SEL_DMRD_W;
                default:             sel_s = SEL_RF;
            endcase
        end else begin
            sel_s = SEL_RF;
        end
    end

    assign sel_o = sel_s;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward controller for a 5-stage pipeline tracking E/M/W producer records.
// Optional HAZARD_STALL_STATS_EN adds a 32-bit stalled-cycle counter output.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       d_valid,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_a3,
    input  logic [1:0] d_kind,
    output logic       stall,
    output logic [3:0] fwd_rs_d,
    output logic [3:0] fwd_rt_d,
    output logic [3:0] fwd_rs_e,
    output logic [3:0] fwd_rt_e
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    stage_rec_t e_q, m_q, w_q;
    stage_rec_t e_d, m_d, w_d;
    logic       stall_s;

    // Only the youngest matching producer decides; an older one is shadowed.
    function automatic logic src_stall(input logic [4:0] src, input logic [1:0] tuse,
                                       input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                       input logic [4:0] m_a3, input logic [1:0] m_tnew);
        logic hit;
        if (tuse == TUSE_UNUSED || src == 5'd0) begin
            hit = 1'b0;
        end else if (e_a3 == src) begin
            hit = (e_tnew > tuse);
        end else if (m_a3 == src) begin
            hit = (m_tnew > tuse);
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    assign stall_s = src_stall(d_rs, d_tuse_rs, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew)
                   | src_stall(d_rt, d_tuse_rt, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew);

    // Next-state of the stage records; a stall injects a bubble into E.
    always_comb begin
        e_d = '0;
        if (!stall_s) begin
            e_d.a3   = (d_valid && (d_kind != 2'd0)) ? d_a3 : 5'd0;
            e_d.kind = kind_e'(d_kind);
            e_d.tnew = tnew_init(kind_e'(d_kind));
            e_d.rs   = d_rs;
            e_d.rt   = d_rt;
        end else begin
            e_d = '0;
        end
        m_d      = e_q;
        m_d.tnew = tnew_dec(e_q.tnew);
        w_d      = m_q;
        w_d.tnew = tnew_dec(m_q.tnew);
    end

    // Stage record registers, cleared to bubbles asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    hazard_fwd_sel u_sel_rs_d (.src_i(d_rs),  .m_rec_i(m_q), .w_rec_i(w_q), .sel_o(fwd_rs_d));
    hazard_fwd_sel u_sel_rt_d (.src_i(d_rt),  .m_rec_i(m_q), .w_rec_i(w_q), .sel_o(fwd_rt_d));
    hazard_fwd_sel u_sel_rs_e (.src_i(e_q.rs), .m_rec_i(m_q), .w_rec_i(w_q), .sel_o(fwd_rs_e));
    hazard_fwd_sel u_sel_rt_e (.src_i(e_q.rt), .m_rec_i(m_q), .w_rec_i(w_q), .sel_o(fwd_rt_e));

    assign stall = stall_s;

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] stall_cnt_q;

    // Stalled-cycle counter, wraps at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= 32'd0;
        end else if (stall_s) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus random
// instruction streams against an instruction-level pipeline model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       d_valid;
    logic [4:0] d_rs, d_rt, d_a3;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_kind;
    logic       stall;
    logic [3:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset_n(reset_n), .d_valid(d_valid),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_a3(d_a3), .d_kind(d_kind), .stall(stall),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e)
`ifdef HAZARD_STALL_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Model: in-flight instructions by position (0=E, 1=M, 2=W).
    typedef struct { int dst; int kind; int rs; int rt; } ins_t;
    ins_t pipe [3];
    int   m_cnt;
    logic m_last_stall;
    logic o_stall;
    logic [3:0] o_rs_d, o_rs_e;

    function automatic int latency(input int kind);
        if (kind == 1 || kind == 2) return 1;
        if (kind == 3) return 2;
        return 0;
    endfunction

    // Cycles until the instruction at position s has its result.
    function automatic int ready_in(input int s);
        int t;
        t = latency(pipe[s].kind) - s;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic logic src_hazard(input int src, input int tuse);
        if (tuse == 3 || src == 0) return 1'b0;
        for (int s = 0; s < 2; s++)
            if (pipe[s].dst == src) return (ready_in(s) > tuse);
        return 1'b0;
    endfunction

    function automatic int model_sel(input int src);
        if (src == 0) return 0;
        if (pipe[1].dst == src) begin
            if (ready_in(1) != 0) return 0;
            return (pipe[1].kind == 1) ? 1 : (pipe[1].kind == 2) ? 2 : 0;
        end
        if (pipe[2].dst == src) return (pipe[2].kind == 3) ? 4 : 3;
        return 0;
    endfunction

    function automatic logic model_stall();
        return src_hazard(int'(d_rs), int'(d_tuse_rs)) | src_hazard(int'(d_rt), int'(d_tuse_rt));
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0};
        m_cnt = 0;
        m_last_stall = 1'b0;
    endtask

    task automatic drive(input logic v, input int rs, input int rt, input int trs,
                         input int trt, input int a3, input int kind);
        d_valid = v;  d_rs = 5'(rs);  d_rt = 5'(rt);
        d_tuse_rs = 2'(trs);  d_tuse_rt = 2'(trt);
        d_a3 = 5'(a3);  d_kind = 2'(kind);
    endtask

    task automatic nop();
        drive(1'b0, 0, 0, 3, 3, 0, 0);
    endtask

    task automatic check_now(input string tag);
        check({tag, ".stall"}, 32'(stall), 32'(model_stall()));
        check({tag, ".rs_d"}, 32'(fwd_rs_d), 32'(model_sel(int'(d_rs))));
        check({tag, ".rt_d"}, 32'(fwd_rt_d), 32'(model_sel(int'(d_rt))));
        check({tag, ".rs_e"}, 32'(fwd_rs_e), 32'(model_sel(pipe[0].rs)));
        check({tag, ".rt_e"}, 32'(fwd_rt_e), 32'(model_sel(pipe[0].rt)));
`ifdef HAZARD_STALL_STATS_EN
        check({tag, ".cnt"}, stall_cnt, 32'(m_cnt));
`endif
    endtask

    // Check at negedge, then advance the model on the following posedge.
    task automatic cycle(input string tag);
        logic st;
        @(negedge clk);
        check_now(tag);
        o_stall = stall;  o_rs_d = fwd_rs_d;  o_rs_e = fwd_rs_e;
        st = model_stall();
        @(posedge clk);
        if (st) m_cnt++;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (st) pipe[0] = '{0, 0, 0, 0};
        else    pipe[0] = '{(d_valid && d_kind != 2'd0) ? int'(d_a3) : 0, int'(d_kind),
                            int'(d_rs), int'(d_rt)};
        m_last_stall = st;
        #1;
    endtask

    task automatic flush();
        nop();
        repeat (3) cycle("flush");
    endtask

    task automatic lw_use(input string tag);
        drive(1'b1, 1, 0, 1, 3, 2, 3);      // lw $2
        cycle({tag, ".lw"});
        drive(1'b1, 2, 0, 1, 3, 3, 1);      // addu $3, $2
        cycle({tag, ".use"});
        check({tag, ".stall1"}, 32'(o_stall), 32'd1);
        cycle({tag, ".use2"});
        check({tag, ".stall2"}, 32'(o_stall), 32'd0);
        nop();
        cycle({tag, ".e"});
        check({tag, ".fwd_e"}, 32'(o_rs_e), 32'd4);
    endtask

    initial begin
        model_clear();
        nop();
        reset_n = 1'b0;
        #12;
        check_now("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // addu $1 then beq $1
        drive(1'b1, 4, 5, 1, 1, 1, 1);
        cycle("beq.addu");
        drive(1'b1, 1, 0, 0, 3, 0, 0);
        cycle("beq.s");
        check("beq.stall1", 32'(o_stall), 32'd1);
        cycle("beq.f");
        check("beq.stall2", 32'(o_stall), 32'd0);
        check("beq.fwd_d", 32'(o_rs_d), 32'd1);
        flush();

        lw_use("lwuse");
        flush();

        // jal then jr $31
        drive(1'b1, 0, 0, 3, 3, 31, 2);
        cycle("jr.jal");
        drive(1'b1, 31, 0, 0, 3, 0, 0);
        cycle("jr.s");
        check("jr.stall1", 32'(o_stall), 32'd1);
        cycle("jr.f");
        check("jr.stall2", 32'(o_stall), 32'd0);
        check("jr.fwd_d", 32'(o_rs_d), 32'd2);
        flush();

        // write to $0 never forwards
        drive(1'b1, 1, 1, 1, 1, 0, 1);
        cycle("r0.alu");
        drive(1'b1, 0, 0, 0, 0, 0, 0);
        cycle("r0.beq");
        check("r0.stall", 32'(o_stall), 32'd0);
        check("r0.fwd_d", 32'(o_rs_d), 32'd0);
        cycle("r0.beq2");
        check("r0.fwd_d2", 32'(o_rs_d), 32'd0);
        flush();

        // reset pulse during a lw-use stall
        drive(1'b1, 1, 0, 1, 3, 2, 3);
        cycle("rst.lw");
        drive(1'b1, 2, 0, 1, 3, 3, 1);
        #1;
        check("rst.pre", 32'(stall), 32'd1);
        reset_n = 1'b0;
        #1;
        model_clear();
        check_now("rst.async");
        check("rst.stall0", 32'(stall), 32'd0);
        #1;
        reset_n = 1'b1;
        cycle("rst.d1");
        nop();
        repeat (3) cycle("rst.after");

        // random streams; D held while stalled
        for (int i = 0; i < 600; i++) begin
            if (!m_last_stall)
                drive(($urandom % 8) != 0, $urandom % 4, $urandom % 4, $urandom % 4,
                      $urandom % 4, $urandom % 4, $urandom % 4);
            cycle("rnd");
        end

`ifdef HAZARD_STALL_STATS_EN
        nop();
        reset_n = 1'b0;
        #1;
        model_clear();
        reset_n = 1'b1;
        lw_use("cnt1");
        lw_use("cnt2");
        lw_use("cnt3");
        check("cnt.three", stall_cnt, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
